bip_program_loader: RTL and testbench

- Writer side of the BIP instruction-fetch path. The control unit reads 16-bit instructions from program memory at PC; this block fills that memory from the UART byte stream.
- While loading, it holds the BIP in reset. When loading completes, it releases the BIP so it fetches from address 0.
- Sits between the UART receiver/transmitter and the program memory write port, inside the BIP_UART top level.

---
 rtl/bip_program_loader_pkg.sv | 21 ++
 rtl/bip_program_loader_timeout_counter.sv | 30 +++
 rtl/bip_program_loader.sv | 121 ++++++++++++
 tb/tb_bip_program_loader.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/bip_program_loader_pkg.sv
// Shared BIP definitions: instruction field split, HALT opcode and the loader FSM encoding.
package bip_defs;

    localparam int INSTR_W = 16;
    localparam logic [4:0] OPCODE_HALT = 5'b00000;

    typedef struct packed {
        logic [4:0]  opcode;
        logic [10:0] operand;
    } instr_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_GET_HI = 3'd1,
        ST_GET_LO = 3'd2,
        ST_WRITE  = 3'd3,
        ST_ACK    = 3'd4,
        ST_RUN    = 3'd5
    } loader_state_t;

endpackage

// File: rtl/bip_program_loader_timeout_counter.sv
// Inter-byte watchdog: counts enabled cycles since the last clear and flags reaching TIMEOUT.
module loader_timeout_counter #(
    parameter int TIMEOUT = 100000
) (
    input  logic clock,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TC = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] r_count;

    // Saturates at the terminal count so o_expired holds until the FSM reacts.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != TC)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_expired = i_enable && (r_count == TC);

endmodule

// File: rtl/bip_program_loader.sv
// Fills BIP program memory from the UART byte stream and holds the CPU in reset until loading ends.
module bip_program_loader
    import bip_defs::*;
#(
    parameter int         ADDR_W    = 11,
    parameter logic [7:0] SYNC_BYTE = 8'h55,
    parameter logic [7:0] ACK_BYTE  = 8'h06,
    parameter int         TIMEOUT   = 100000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [7:0]         rx_data,
    input  logic               rx_done,
    input  logic               tx_busy,
    output logic               tx_start,
    output logic [7:0]         tx_data,
    output logic               prog_we,
    output logic [ADDR_W-1:0]  prog_addr,
    output logic [INSTR_W-1:0] prog_wdata,
    output logic               cpu_hold,
    output logic               load_done,
    output logic               load_err
);

    loader_state_t     r_state, w_state_next;
    logic [ADDR_W-1:0] r_addr, w_addr_next;
    instr_t            r_word, w_word_next;
    logic              r_load_err, w_load_err_next;
    logic              w_in_get;
    logic              w_timeout;

    assign w_in_get = (r_state == ST_GET_HI) || (r_state == ST_GET_LO);

    loader_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clock     (clock),
        .reset     (reset),
        .i_clear   (rx_done || !w_in_get),
        .i_enable  (w_in_get),
        .o_expired (w_timeout)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_addr     <= '0;
            r_word     <= '0;
            r_load_err <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_addr     <= w_addr_next;
            r_word     <= w_word_next;
            r_load_err <= w_load_err_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_addr_next     = r_addr;
        w_word_next     = r_word;
        w_load_err_next = r_load_err;
        case (r_state)
            ST_IDLE, ST_RUN: begin
                if (rx_done && (rx_data == SYNC_BYTE)) begin
                    w_state_next    = ST_GET_HI;
                    w_addr_next     = '0;
                    w_load_err_next = 1'b0;
                end
            end
            ST_GET_HI: begin
                if (rx_done) begin
                    w_word_next  = instr_t'({rx_data, r_word[7:0]});
                    w_state_next = ST_GET_LO;
                end else if (w_timeout) begin
                    w_load_err_next = 1'b1;
                    w_state_next    = ST_IDLE;
                end
            end
            ST_GET_LO: begin
                if (rx_done) begin
                    w_word_next  = instr_t'({r_word[15:8], rx_data});
                    w_state_next = ST_WRITE;
                end else if (w_timeout) begin
                    w_load_err_next = 1'b1;
                    w_state_next    = ST_IDLE;
                end
            end
            ST_WRITE: begin
                w_state_next = ST_ACK;
            end
            ST_ACK: begin
                // The ACK goes out in the cycle tx_busy is low, so the next state is decided then too.
                if (!tx_busy) begin
                    if (r_word.opcode == OPCODE_HALT) begin
                        w_state_next = ST_RUN;
                    end else if (&r_addr) begin
                        w_load_err_next = 1'b1;
                        w_state_next    = ST_RUN;
                    end else begin
                        w_addr_next  = r_addr + ADDR_W'(1);
                        w_state_next = ST_GET_HI;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign prog_we    = (r_state == ST_WRITE);
    assign prog_addr  = r_addr;
    assign prog_wdata = r_word;
    assign tx_start   = (r_state == ST_ACK) && !tx_busy;
    assign tx_data    = (r_state == ST_ACK) ? ACK_BYTE : 8'h00;
    assign cpu_hold   = (r_state != ST_RUN);
    assign load_done  = (r_state == ST_RUN) && !r_load_err;
    assign load_err   = r_load_err;

endmodule

// File: tb/tb_bip_program_loader.sv
// Directed bench for bip_program_loader with a 4-word memory and a short watchdog.
module tb_bip_program_loader;

    localparam int ADDR_W  = 2;
    localparam int TIMEOUT = 40;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [7:0]        rx_data = 8'h00;
    logic              rx_done = 1'b0;
    logic              tx_busy = 1'b0;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [15:0]       prog_wdata;
    logic              cpu_hold;
    logic              load_done;
    logic              load_err;

    int n_checks = 0;
    int n_errors = 0;
    int we_count = 0;
    int tx_count = 0;
    int we_snap;
    int tx_snap;

    bip_program_loader #(
        .ADDR_W    (ADDR_W),
        .SYNC_BYTE (8'h55),
        .ACK_BYTE  (8'h06),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_done    (rx_done),
        .tx_busy    (tx_busy),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_wdata (prog_wdata),
        .cpu_hold   (cpu_hold),
        .load_done  (load_done),
        .load_err   (load_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (prog_we) begin
            we_count++;
            $display("write addr=%0d data=%04h", prog_addr, prog_wdata);
        end
        if (tx_start) begin
            tx_count++;
            $display("tx byte=%02h", tx_data);
        end
        if (prog_we && tx_start) check("we_tx_same_cycle", 32'd1, 32'd0);
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clock); #1;
        rx_data = b;
        rx_done = 1'b1;
        @(posedge clock); #1;
        rx_done = 1'b0;
        $display("rx byte=%02h", b);
    endtask

    task automatic send_word(input logic [7:0] hi, input logic [7:0] lo, input logic [31:0] exp_addr);
        send_byte(hi);
        send_byte(lo);
        @(negedge clock);
        check("we", prog_we, 1);
        check("addr", prog_addr, exp_addr);
        check("wdata", prog_wdata, {16'h0, hi, lo});
        check("tx_in_write", tx_start, 0);
        @(negedge clock);
        check("tx_start", tx_start, 1);
        check("tx_data", tx_data, 32'h06);
        check("we_in_ack", prog_we, 0);
        check("hold_in_ack", cpu_hold, 1);
        @(posedge clock); #1;
    endtask

    initial begin
        // reset values
        repeat (3) @(negedge clock);
        check("rst_hold", cpu_hold, 1);
        check("rst_done", load_done, 0);
        check("rst_err", load_err, 0);
        check("rst_we", prog_we, 0);
        check("rst_addr", prog_addr, 0);
        check("rst_wdata", prog_wdata, 0);
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_data", tx_data, 0);
        @(posedge clock); #1;
        reset = 1'b0;

        // normal load
        we_snap = we_count; tx_snap = tx_count;
        send_byte(8'h55);
        send_word(8'h08, 8'h01, 0);
        send_word(8'h10, 8'h02, 1);
        send_word(8'h00, 8'h00, 2);
        check("norm_hold", cpu_hold, 0);
        check("norm_done", load_done, 1);
        check("norm_err", load_err, 0);
        check("norm_writes", we_count - we_snap, 3);
        check("norm_acks", tx_count - tx_snap, 3);

        // junk before sync
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        we_snap = we_count;
        send_byte(8'hAA);
        send_byte(8'h13);
        repeat (3) @(posedge clock);
        #1;
        check("junk_writes", we_count - we_snap, 0);
        check("junk_hold", cpu_hold, 1);
        send_byte(8'h55);
        send_word(8'h00, 8'h00, 0);
        check("junk_writes_after", we_count - we_snap, 1);
        check("junk_done", load_done, 1);

        // slow low byte inside the watchdog window is accepted
        send_byte(8'h55);
        send_byte(8'h00);
        repeat (35) @(posedge clock);
        #1;
        send_byte(8'h07);
        @(negedge clock);
        check("slow_we", prog_we, 1);
        check("slow_wdata", prog_wdata, 32'h0007);
        repeat (2) @(posedge clock);
        #1;
        check("slow_done", load_done, 1);

        // timeout
        we_snap = we_count;
        send_byte(8'h55);
        send_byte(8'h08);
        repeat (TIMEOUT + 5) @(posedge clock);
        #1;
        check("to_writes", we_count - we_snap, 0);
        check("to_err", load_err, 1);
        check("to_hold", cpu_hold, 1);
        check("to_done", load_done, 0);

        // sync clears the error, then overflow
        send_byte(8'h55);
        check("sync_clr_err", load_err, 0);
        we_snap = we_count;
        for (int i = 0; i < 4; i++) send_word(8'h08, 8'h00, i);
        check("ovf_writes", we_count - we_snap, 4);
        check("ovf_err", load_err, 1);
        check("ovf_hold", cpu_hold, 0);
        check("ovf_done", load_done, 0);

        // reload and tx_busy backpressure
        send_byte(8'h55);
        check("reload_hold", cpu_hold, 1);
        check("reload_done", load_done, 0);
        check("reload_err", load_err, 0);
        tx_busy = 1'b1;
        tx_snap = tx_count;
        send_byte(8'h00);
        send_byte(8'h05);
        @(negedge clock);
        check("bp_we", prog_we, 1);
        check("bp_addr", prog_addr, 0);
        repeat (50) @(negedge clock);
        check("bp_no_tx", tx_count - tx_snap, 0);
        check("bp_hold", cpu_hold, 1);
        @(posedge clock); #1;
        tx_busy = 1'b0;
        @(negedge clock);
        check("bp_tx_start", tx_start, 1);
        @(posedge clock); #1;
        check("bp_one_tx", tx_count - tx_snap, 1);
        check("bp_done", load_done, 1);

        // reload then async reset between hi and lo bytes
        send_byte(8'h55);
        check("rl_hold", cpu_hold, 1);
        send_word(8'h08, 8'h00, 0);
        send_byte(8'h08);
        check("addr_before_rst", prog_addr, 1);
        #2;
        reset = 1'b1;
        #1;
        check("arst_hold", cpu_hold, 1);
        check("arst_addr", prog_addr, 0);
        check("arst_wdata", prog_wdata, 0);
        check("arst_we", prog_we, 0);
        check("arst_tx_start", tx_start, 0);
        check("arst_tx_data", tx_data, 0);
        check("arst_done", load_done, 0);
        check("arst_err", load_err, 0);
        @(posedge clock); #1;
        reset = 1'b0;
        repeat (2) @(posedge clock);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
